// File: rtl/keysweep_pkg.sv
// rtl/keysweep_pkg.sv - shared types and default geometry for the key-sweep sequencer
package keysweep_pkg;

   localparam int DEF_KEY_W = 4;
   localparam int DEF_PI_W  = 36;
   localparam int DEF_PO_W  = 7;
   localparam int NKEYS     = 2 ** DEF_KEY_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SCAN,
      S_WAIT,
      S_CMP,
      S_DONE
   } state_t;

endpackage

// File: rtl/keysweep_popcnt.sv
// rtl/keysweep_popcnt.sv - combinational population count of the survivor vector
module keysweep_popcnt #(
   parameter int N  = 16,
   parameter int CW = 5
) (
   input  logic [N-1:0]  bits,
   output logic [CW-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/keysweep_ctrl.sv
// rtl/keysweep_ctrl.sv - candidate-key elimination sweep over a locked combinational core
// Optional: KEYSWEEP_EARLY_EXIT_EN ends the sweep once at most one key survives a pattern.
module keysweep_ctrl
   import keysweep_pkg::*;
#(
   parameter int KEY_W  = DEF_KEY_W,
   parameter int PI_W   = DEF_PI_W,
   parameter int PO_W   = DEF_PO_W,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_W-1:0]      num_pat,
   input  logic                  pat_valid,
   output logic                  pat_ready,
   input  logic [PI_W-1:0]       pat_pi,
   input  logic [PO_W-1:0]       pat_oracle,
   output logic [KEY_W-1:0]      key_o,
   output logic [PI_W-1:0]       pi_o,
   input  logic [PO_W-1:0]       po_i,
   output logic                  busy,
   output logic                  done,
   output logic [2**KEY_W-1:0]   survivors,
   output logic [KEY_W:0]        surv_cnt
);

   localparam int NK = 2 ** KEY_W;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t           state;
   logic [KEY_W-1:0] key_idx;
   logic [CNT_W-1:0] pat_cnt;
   logic [CNT_W-1:0] num_lat;
   logic [PO_W-1:0]  oracle;
   logic [SW-1:0]    settle;
   logic [KEY_W:0]   pop_now;
   logic             last_key;
   logic             last_pat;
   logic             miss;
   logic             stop;

   keysweep_popcnt #(.N(NK), .CW(KEY_W + 1)) u_pop (
      .bits (survivors),
      .cnt  (pop_now)
   );

   assign pat_ready = (state == S_FETCH);
   assign last_key  = &key_idx;
   assign last_pat  = (pat_cnt + CNT_W'(1)) == num_lat;
   assign miss      = (po_i != oracle);

`ifdef KEYSWEEP_EARLY_EXIT_EN
   // The registered count lags the survivor bits, so judge on the post-compare vector.
   logic [NK-1:0]  surv_post;
   logic [KEY_W:0] pop_post;

   assign surv_post = (state == S_CMP && miss) ? (survivors & ~(NK'(1) << key_idx)) : survivors;

   keysweep_popcnt #(.N(NK), .CW(KEY_W + 1)) u_pop_post (
      .bits (surv_post),
      .cnt  (pop_post)
   );

   assign stop = last_pat || (pop_post <= (KEY_W + 1)'(1));
`else
   assign stop = last_pat;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         key_o     <= '0;
         pi_o      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         survivors <= '1;
         surv_cnt  <= (KEY_W + 1)'(NK);
         key_idx   <= '0;
         pat_cnt   <= '0;
         num_lat   <= '0;
         oracle    <= '0;
         settle    <= '0;
      end else begin
         done     <= 1'b0;
         surv_cnt <= pop_now;
         case (state)
            S_IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  survivors <= '1;
                  pat_cnt   <= '0;
                  num_lat   <= num_pat;
                  busy      <= 1'b1;
                  state     <= (num_pat == '0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: begin
               if (pat_valid) begin
                  pi_o    <= pat_pi;
                  oracle  <= pat_oracle;
                  key_idx <= '0;
                  state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (survivors[key_idx]) begin
                  key_o  <= key_idx;
                  settle <= SW'(SETTLE - 1);
                  state  <= S_WAIT;
               end else if (!last_key) begin
                  key_idx <= key_idx + KEY_W'(1);
               end else begin
                  pat_cnt <= pat_cnt + CNT_W'(1);
                  state   <= stop ? S_DONE : S_FETCH;
               end
            end
            S_WAIT: begin
               if (settle == '0) begin
                  state <= S_CMP;
               end else begin
                  settle <= settle - SW'(1);
               end
            end
            S_CMP: begin
               if (miss) begin
                  survivors[key_idx] <= 1'b0;
               end
               if (!last_key) begin
                  key_idx <= key_idx + KEY_W'(1);
                  state   <= S_SCAN;
               end else begin
                  pat_cnt <= pat_cnt + CNT_W'(1);
                  state   <= stop ? S_DONE : S_FETCH;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/keysweep_ctrl.md
# keysweep_ctrl

Sequencer that recovers the key of a key-locked combinational core (e.g. a c432 variant with a 4-bit key on D_0..D_3 driving input muxes). It fetches test patterns paired with oracle responses, drives each surviving candidate key plus the pattern into the locked core, and compares the core's outputs to the oracle. Keys that mismatch are eliminated. It sits between the pattern/oracle buffer and the locked-core instance in the deobfuscation harness.

## Interface
- KEY_W, 4, key width; candidate space is 2^KEY_W
- PI_W, 36, primary-input width of locked core
- PO_W, 7, primary-output width of locked core
- SETTLE, 2, cycles waited after driving key/pattern before sampling po_i (≥1)
- CNT_W, 16, width of pattern counter
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- num_pat  in  CNT_W  patterns to consume; sampled on accepted start; 0 → immediate DONE
- pat_valid  in  1  pattern source has pi/oracle available
- pat_ready  out  1  controller accepts pattern this cycle
- pat_pi  in  PI_W  pattern inputs
- pat_oracle  in  PO_W  expected outputs from unlocked reference
- key_o  out  KEY_W  key to locked core
- pi_o  out  PI_W  inputs to locked core
- po_i  in  PO_W  locked-core outputs (combinational from key_o/pi_o)
- busy  out  1  high from accepted start through DONE
- done  out  1  one-cycle pulse at sweep end
- survivors  out  2^KEY_W  bit k = key k still consistent
- surv_cnt  out  KEY_W+1  popcount of survivors

## Operation
- States: IDLE, FETCH, SCAN, WAIT, CMP, DONE.
- IDLE: start=1 → survivors all-ones, pat_cnt=0, latch num_pat; num_pat=0 → DONE, else FETCH.
- FETCH: pat_ready=1; on pat_valid latch pat_pi→pi_o, pat_oracle→oracle reg, key_idx=0 → SCAN.
- SCAN: survivors[key_idx]=0 → skip (advance rule); else key_o=key_idx, settle counter=SETTLE-1 → WAIT.
- WAIT: decrement; at 0 → CMP.
- CMP: po_i≠oracle → clear survivors[key_idx]; then advance rule.
- Advance rule: key_idx<2^KEY_W-1 → key_idx+1, SCAN; else pat_cnt+1; pat_cnt+1==num_pat → DONE, else FETCH.
- DONE: done=1 one cycle, busy=0 next cycle → IDLE. survivors/surv_cnt hold until next accepted start.
- start outside IDLE ignored. pat_valid outside FETCH ignored (pat_ready=0).
- Zero survivors is legal; sweep continues to num_pat (without early exit).

## Timing
- Reset: state IDLE, key_o=0, pi_o=0, pat_ready=0, busy=0, done=0, survivors=all-ones, surv_cnt=2^KEY_W, counters 0.
- All outputs registered except pat_ready (decoded from state==FETCH).
- Start accepted at edge N → busy=1 at N+1.
- Live key cost: 1 (SCAN) + SETTLE (WAIT) + 1 (CMP) cycles; dead key: 1 cycle.
- Pattern transfer on edge where pat_valid&pat_ready; FETCH stalls indefinitely while pat_valid=0.
- surv_cnt updates the cycle after the survivors bit changes.
- rst mid-sweep: return to reset values next edge; in-flight pattern discarded.

## Configuration
- KEYSWEEP_EARLY_EXIT_EN defined: in advance rule, after any pattern completes, surv_cnt≤1 → DONE regardless of pat_cnt (check uses post-CMP count).
- Undefined: always consumes exactly num_pat patterns.

## Structure
- Package keysweep_pkg: state enum, default KEY_W/PI_W/PO_W, NKEYS=2**KEY_W constant.
- Sub-module keysweep_popcnt: combinational popcount of survivors, registered in parent into surv_cnt.

## Test plan
- Locked-core model with correct key 4'h6, num_pat=8 random patterns → done; survivors=16'h0040, surv_cnt=1.
- Model where keys 4'h6 and 4'h9 are functionally equivalent → survivors=16'h0240, surv_cnt=2.
- num_pat=0 → done two cycles after start, survivors=16'hFFFF, no pat_ready.
- pat_valid held low 20 cycles in FETCH → pat_ready stays 1, no key_o change; resumes correctly.
- SETTLE=2, pattern 1 kills 15 keys → pattern 2 takes 15 skip cycles + 4 for key 6; measure exact cycle count.
- rst asserted in WAIT of pattern 3 → all outputs at reset values next cycle; new start runs full sweep; with KEYSWEEP_EARLY_EXIT_EN, num_pat=8 ends after first pattern reaching surv_cnt=1.
